mem_port_arbiter: RTL and testbench

- Two-requester arbiter that shares the single data-memory port of the KGP-RISC core.
- Requester A is instruction fetch; requester B is load/store.
- Sequences each access (issue, wait for read latency, acknowledge) and drives the `sel` line of the 2:1 port muxes (sel=0 selects A, sel=1 selects B).
- Round-robin fairness by default.

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_pick.sv | 33 +++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - state encodings and grant constants for the memory port arbiter
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } arb_state_e;

   localparam logic GRANT_A = 1'b0;
   localparam logic GRANT_B = 1'b1;

   // Wide enough for MEM_LAT-1 up to the supported latency of 15.
   localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// rtl/mem_port_arbiter_pick.sv - two-way grant selection (ARB_FIXED_PRIO_EN: B always wins a contest)
module arb_pick_2 (
   input  logic req_a,
   input  logic req_b,
   input  logic last_grant,
   input  logic mask_a,
   input  logic mask_b,
   output logic gnt_valid,
   output logic gnt
);
   import mem_port_arbiter_pkg::*;

   logic eff_a;
   logic eff_b;

   assign eff_a     = req_a & ~mask_a;
   assign eff_b     = req_b & ~mask_b;
   assign gnt_valid = eff_a | eff_b;

   always_comb begin
      gnt = GRANT_A;
      if (eff_a && eff_b) begin
`ifdef ARB_FIXED_PRIO_EN
         gnt = GRANT_B;
`else
         gnt = ~last_grant;
`endif
      end else if (eff_b) begin
         gnt = GRANT_B;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch vs load/store arbiter for the shared data-memory port
// Round-robin by default; ARB_FIXED_PRIO_EN selects fixed B-first priority.
module mem_port_arbiter #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 10,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              sel,
   output logic              busy
);
   import mem_port_arbiter_pkg::*;

   localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(MEM_LAT - 1);

   arb_state_e           state_q, state_d;
   logic                 sel_q, sel_d;
   logic                 last_grant_q, last_grant_d;
   logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;

   logic in_ack;
   logic mask_a;
   logic mask_b;
   logic gnt_valid;
   logic gnt;

   // The requester being acknowledged cannot win the follow-on contest.
   assign in_ack = (state_q == ST_ACK);
   assign mask_a = in_ack && (sel_q == GRANT_A);
   assign mask_b = in_ack && (sel_q == GRANT_B);

   arb_pick_2 u_pick (
      .req_a      (a_req),
      .req_b      (b_req),
      .last_grant (last_grant_q),
      .mask_a     (mask_a),
      .mask_b     (mask_b),
      .gnt_valid  (gnt_valid),
      .gnt        (gnt)
   );

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      last_grant_d = last_grant_q;
      lat_cnt_d    = lat_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_valid) begin
               state_d = ST_ISSUE;
               sel_d   = gnt;
            end
         end
         ST_ISSUE: begin
            if (MEM_LAT > 1) begin
               state_d   = ST_WAIT;
               lat_cnt_d = LAT_CNT_W'(1);
            end else begin
               state_d = ST_ACK;
            end
         end
         ST_WAIT: begin
            if (lat_cnt_q == LAT_LAST) begin
               state_d   = ST_ACK;
               lat_cnt_d = '0;
            end else begin
               lat_cnt_d = lat_cnt_q + 1'b1;
            end
         end
         ST_ACK: begin
            last_grant_d = sel_q;
            if (gnt_valid) begin
               state_d = ST_ISSUE;
               sel_d   = gnt;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         sel_q        <= GRANT_A;
         last_grant_q <= GRANT_B;
         lat_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         last_grant_q <= last_grant_d;
         lat_cnt_q    <= lat_cnt_d;
      end
   end

   // Address and data stay muxed for the whole access; zero while idle.
   assign sel       = sel_q;
   assign busy      = (state_q != ST_IDLE);
   assign mem_en    = (state_q == ST_ISSUE);
   assign mem_we    = mem_en && (sel_q ? b_we : a_we);
   assign mem_addr  = busy ? (sel_q ? b_addr : a_addr) : '0;
   assign mem_wdata = busy ? (sel_q ? b_wdata : a_wdata) : '0;

   assign a_ack   = in_ack && (sel_q == GRANT_A);
   assign b_ack   = in_ack && (sel_q == GRANT_B);
   assign a_rdata = a_ack ? mem_rdata : '0;
   assign b_rdata = b_ack ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized bench for mem_port_arbiter at MEM_LAT=1 and MEM_LAT=3
module tb_mem_port_arbiter;

   localparam int DW   = 32;
   localparam int AW   = 10;
   localparam int LAT0 = 1;
   localparam int LAT1 = 3;

   logic clk = 1'b0;
   logic rst;
   logic mem_init;

   logic          a_req [2], a_we [2], b_req [2], b_we [2];
   logic [AW-1:0] a_addr [2], b_addr [2], mem_addr [2];
   logic [DW-1:0] a_wdata [2], b_wdata [2], a_rdata [2], b_rdata [2];
   logic [DW-1:0] mem_wdata [2], mem_rdata [2];
   logic          a_ack [2], b_ack [2], mem_en [2], mem_we [2], sel [2], busy [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_port_arbiter #(
         .DATA_W  (DW),
         .ADDR_W  (AW),
         .MEM_LAT ((g == 0) ? LAT0 : LAT1)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .a_req     (a_req[g]),
         .a_we      (a_we[g]),
         .a_addr    (a_addr[g]),
         .a_wdata   (a_wdata[g]),
         .a_ack     (a_ack[g]),
         .a_rdata   (a_rdata[g]),
         .b_req     (b_req[g]),
         .b_we      (b_we[g]),
         .b_addr    (b_addr[g]),
         .b_wdata   (b_wdata[g]),
         .b_ack     (b_ack[g]),
         .b_rdata   (b_rdata[g]),
         .mem_en    (mem_en[g]),
         .mem_we    (mem_we[g]),
         .mem_addr  (mem_addr[g]),
         .mem_wdata (mem_wdata[g]),
         .mem_rdata (mem_rdata[g]),
         .sel       (sel[g]),
         .busy      (busy[g])
      );
   end

   function automatic logic [DW-1:0] init_val(int k, int a);
      logic [DW-1:0] v;
      v = (32'(a) * 32'h9E37_79B9) ^ 32'(k);
      if (a == 4) v = 32'hDEAD_BEEF;
      return v;
   endfunction

   function automatic int lat_of(int k);
      return (k == 0) ? LAT0 : LAT1;
   endfunction

   // Memory behind the port: read data appears after the strobe and is held.
   logic [DW-1:0] mem_arr [2][1024];
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (mem_init) begin
            for (int a = 0; a < 1024; a++) mem_arr[k][a] <= init_val(k, a);
         end else if (mem_en[k]) begin
            if (mem_we[k]) mem_arr[k][mem_addr[k]] <= mem_wdata[k];
            else           mem_rdata[k] <= mem_arr[k][mem_addr[k]];
         end
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: one access at a time, each spanning issue..issue+LAT.
   logic [DW-1:0] ref_mem [2][1024];
   bit            m_busy [2], m_grant [2], m_last [2], m_sel [2], m_we [2];
   int            m_issue [2];
   logic [AW-1:0] m_addr [2];
   logic [DW-1:0] m_wdata [2], m_rdata [2];

   bit            p_rst;
   logic          p_areq [2], p_awe [2], p_breq [2], p_bwe [2];
   logic [AW-1:0] p_aaddr [2], p_baddr [2];
   logic [DW-1:0] p_awdata [2], p_bwdata [2];

   int cyc;
   int mode;
   bit a_pend [2], b_pend [2];
   int n_a_ack [2], n_b_ack [2];

   function automatic bit pick(logic [1:0] r, bit last);
      if (r == 2'b01) return 1'b0;
      if (r == 2'b10) return 1'b1;
`ifdef ARB_FIXED_PRIO_EN
      return 1'b1;
`else
      return ~last;
`endif
   endfunction

   task automatic model_update(int k);
      logic [1:0] r;
      bit         g;
      if (p_rst) begin
         m_busy[k] = 0;
         m_last[k] = 1;
         m_sel[k]  = 0;
      end else begin
         r = {p_breq[k], p_areq[k]};
         if (m_busy[k] && (cyc - 1 == m_issue[k] + lat_of(k))) begin
            m_last[k]     = m_grant[k];
            m_busy[k]     = 0;
            r[m_grant[k]] = 1'b0;
         end
         if (!m_busy[k] && r != 2'b00) begin
            g          = pick(r, m_last[k]);
            m_busy[k]  = 1;
            m_grant[k] = g;
            m_sel[k]   = g;
            m_issue[k] = cyc;
            m_we[k]    = g ? p_bwe[k] : p_awe[k];
            m_addr[k]  = g ? p_baddr[k] : p_aaddr[k];
            m_wdata[k] = g ? p_bwdata[k] : p_awdata[k];
            if (m_we[k]) ref_mem[k][m_addr[k]] = m_wdata[k];
            else         m_rdata[k] = ref_mem[k][m_addr[k]];
         end
      end
   endtask

   task automatic compare(int k);
      bit e_en, e_ack, e_aack, e_back;
      e_en   = m_busy[k] && (cyc == m_issue[k]);
      e_ack  = m_busy[k] && (cyc == m_issue[k] + lat_of(k));
      e_aack = e_ack && (m_grant[k] == 1'b0);
      e_back = e_ack && (m_grant[k] == 1'b1);
      check($sformatf("busy%0d@%0d", k, cyc), 64'(busy[k]), 64'(m_busy[k]));
      check($sformatf("mem_en%0d@%0d", k, cyc), 64'(mem_en[k]), 64'(e_en));
      check($sformatf("mem_we%0d@%0d", k, cyc), 64'(mem_we[k]), 64'(e_en && m_we[k]));
      check($sformatf("sel%0d@%0d", k, cyc), 64'(sel[k]), 64'(m_sel[k]));
      check($sformatf("a_ack%0d@%0d", k, cyc), 64'(a_ack[k]), 64'(e_aack));
      check($sformatf("b_ack%0d@%0d", k, cyc), 64'(b_ack[k]), 64'(e_back));
      if (m_busy[k]) begin
         check($sformatf("mem_addr%0d@%0d", k, cyc), 64'(mem_addr[k]), 64'(m_addr[k]));
         check($sformatf("mem_wdata%0d@%0d", k, cyc), 64'(mem_wdata[k]), 64'(m_wdata[k]));
      end
      if (p_rst) begin
         check($sformatf("rst_addr%0d@%0d", k, cyc), 64'(mem_addr[k]), 64'd0);
         check($sformatf("rst_wdata%0d@%0d", k, cyc), 64'(mem_wdata[k]), 64'd0);
      end
      if (e_aack && !m_we[k])
         check($sformatf("a_rdata%0d@%0d", k, cyc), 64'(a_rdata[k]), 64'(m_rdata[k]));
      else if (!e_aack)
         check($sformatf("a_rdata_idle%0d@%0d", k, cyc), 64'(a_rdata[k]), 64'd0);
      if (e_back && !m_we[k])
         check($sformatf("b_rdata%0d@%0d", k, cyc), 64'(b_rdata[k]), 64'(m_rdata[k]));
      else if (!e_back)
         check($sformatf("b_rdata_idle%0d@%0d", k, cyc), 64'(b_rdata[k]), 64'd0);
   endtask

   function automatic logic [AW-1:0] rand_addr();
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a = 10'h3FF;
      return a;
   endfunction

   task automatic new_a(int k);
      a_req[k]   = ($urandom_range(0, 2) != 0);
      a_we[k]    = 1'($urandom_range(0, 1));
      a_addr[k]  = rand_addr();
      a_wdata[k] = $urandom;
   endtask

   task automatic new_b(int k);
      b_req[k]   = ($urandom_range(0, 2) != 0);
      b_we[k]    = 1'($urandom_range(0, 1));
      b_addr[k]  = rand_addr();
      b_wdata[k] = $urandom;
   endtask

   // mode 0: hold inputs; mode 1: drop req after ack; mode 2: random traffic
   task automatic drive(int k);
      if (a_pend[k]) begin
         a_pend[k] = 0;
         if (mode == 1) a_req[k] = 1'b0;
         else if (mode == 2) new_a(k);
      end else if (mode == 2 && !a_req[k] && $urandom_range(0, 3) == 0) begin
         new_a(k);
      end
      if (b_pend[k]) begin
         b_pend[k] = 0;
         if (mode == 1) b_req[k] = 1'b0;
         else if (mode == 2) new_b(k);
      end else if (mode == 2 && !b_req[k] && $urandom_range(0, 3) == 0) begin
         new_b(k);
      end
      if (a_ack[k] === 1'b1) begin
         a_pend[k] = 1;
         n_a_ack[k]++;
      end
      if (b_ack[k] === 1'b1) begin
         b_pend[k] = 1;
         n_b_ack[k]++;
      end
   endtask

   task automatic step();
      p_rst    = rst;
      p_areq   = a_req;
      p_awe    = a_we;
      p_aaddr  = a_addr;
      p_awdata = a_wdata;
      p_breq   = b_req;
      p_bwe    = b_we;
      p_baddr  = b_addr;
      p_bwdata = b_wdata;
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < 2; k++) begin
         model_update(k);
         compare(k);
         drive(k);
      end
   endtask

   task automatic set_a(logic req, logic we, logic [AW-1:0] addr, logic [DW-1:0] wd);
      for (int k = 0; k < 2; k++) begin
         a_req[k] = req; a_we[k] = we; a_addr[k] = addr; a_wdata[k] = wd;
      end
   endtask

   task automatic set_b(logic req, logic we, logic [AW-1:0] addr, logic [DW-1:0] wd);
      for (int k = 0; k < 2; k++) begin
         b_req[k] = req; b_we[k] = we; b_addr[k] = addr; b_wdata[k] = wd;
      end
   endtask

   initial begin
      cyc      = 0;
      mode     = 0;
      rst      = 1'b1;
      mem_init = 1'b1;
      set_a(1'b0, 1'b0, '0, '0);
      set_b(1'b0, 1'b0, '0, '0);
      for (int k = 0; k < 2; k++) begin
         for (int a = 0; a < 1024; a++) ref_mem[k][a] = init_val(k, a);
         m_busy[k] = 0; m_last[k] = 1; m_sel[k] = 0; m_grant[k] = 0; m_issue[k] = 0;
         a_pend[k] = 0; b_pend[k] = 0; n_a_ack[k] = 0; n_b_ack[k] = 0;
      end
      step();
      mem_init = 1'b0;

      // A request during reset is ignored.
      set_a(1'b1, 1'b0, 10'h004, '0);
      step();
      rst = 1'b0;
      set_a(1'b0, 1'b0, 10'h004, '0);
      repeat (2) step();

      // Single read of word 4.
      mode = 1;
      set_a(1'b1, 1'b0, 10'h004, '0);
      repeat (8) step();

      // Both requesting continuously straight out of reset.
      mode = 0;
      rst  = 1'b1;
      set_a(1'b1, 1'b0, 10'h004, '0);
      set_b(1'b1, 1'b0, 10'h010, '0);
      for (int k = 0; k < 2; k++) begin n_a_ack[k] = 0; n_b_ack[k] = 0; end
      step();
      rst = 1'b0;
      repeat (8) step();
      check("rr_a_acks_lat1", 64'(n_a_ack[0]), 64'd2);
      check("rr_b_acks_lat1", 64'(n_b_ack[0]), 64'd2);
      check("rr_a_acks_lat3", 64'(n_a_ack[1]), 64'd1);
      check("rr_b_acks_lat3", 64'(n_b_ack[1]), 64'd1);
      rst = 1'b1;
      set_a(1'b0, 1'b0, '0, '0);
      set_b(1'b0, 1'b0, '0, '0);
      step();
      rst = 1'b0;
      step();

      // B writes the top word.
      mode = 1;
      set_b(1'b1, 1'b1, 10'h3FF, 32'h0000_00A5);
      repeat (8) step();
      check("wr_3ff_lat1", 64'(mem_arr[0][10'h3FF]), 64'h0000_00A5);
      check("wr_3ff_lat3", 64'(mem_arr[1][10'h3FF]), 64'h0000_00A5);

      // Reset while the MEM_LAT=3 instance is waiting.
      set_a(1'b1, 1'b0, 10'h008, '0);
      repeat (2) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_a(1'b0, 1'b0, '0, '0);
      step();
      set_a(1'b1, 1'b0, 10'h00C, '0);
      set_b(1'b1, 1'b0, 10'h00D, '0);
      step();
      check("post_rst_first_sel_lat1", 64'(sel[0]), 64'd0);
      check("post_rst_first_sel_lat3", 64'(sel[1]), 64'd0);
      repeat (12) step();

      // Random traffic with occasional resets.
      mode = 2;
      repeat (3000) begin
         rst = ($urandom_range(0, 99) == 0);
         step();
      end
      rst = 1'b0;
      repeat (10) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
